// File: rtl/add64_sequencer_if.sv
// ---------------------------------------------------------------------------
// add64_sequencer_if
// Groups the operand, handshake and result signals of add64_sequencer.
//   start  : request a new operation (taken only while ready=1)
//   sub    : 0 = a+b, 1 = a-b, captured with start
//   a, b   : 64-bit operands, captured with start
//   ready  : sequencer can take start this cycle
//   busy   : operation in progress
//   done   : one-cycle pulse, result/cout/ovf valid
//   result : 64-bit sum or difference
//   cout   : carry out of bit 63 (subtract: 1 = no borrow)
//   ovf    : two's-complement signed overflow
// master = requester side, slave = sequencer side.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

interface add64_sequencer_if;
    logic        start;
    logic        sub;
    logic [63:0] a;
    logic [63:0] b;
    logic        ready;
    logic        busy;
    logic        done;
    logic [63:0] result;
    logic        cout;
    logic        ovf;

    modport master (
        output start, sub, a, b,
        input  ready, busy, done, result, cout, ovf
    );

    modport slave (
        input  start, sub, a, b,
        output ready, busy, done, result, cout, ovf
    );
endinterface

// File: rtl/add64_sequencer.sv
// ---------------------------------------------------------------------------
// add64_sequencer
// 64-bit add/subtract built from a single 16-bit carry-lookahead slice that
// is reused over four cycles, least significant slice first.
// Ports:
//   clk   : sole clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : add64_sequencer_if.slave (start/sub/a/b in, ready/busy/done/
//           result/cout/ovf out)
// Timing: accept at edge k, slice edges k+1..k+4, done high k+4..k+5.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start, ready=1
// RUN   | one 16-bit slice per cycle, idx selects the slice, busy=1
// DONE  | result/cout/ovf valid for one cycle, ready=1 (back-to-back)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module add64_sequencer_cla16 (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        cin,
    output logic [15:0] s,
    output logic        cout
);
    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] c;
    logic [3:0]  gg;
    logic [3:0]  gp;
    logic [4:0]  bc;

    // Two-level lookahead: group generate/propagate per nibble, block
    // carries from the groups, then bit carries inside each nibble.
    always_comb begin
        g = x & y;
        p = x ^ y;
        for (int k = 0; k < 4; k++) begin
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            gp[k] = p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k];
        end

        bc[0] = cin;
        bc[1] = gg[0] | (gp[0] & cin);
        bc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
        bc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
              | (gp[2] & gp[1] & gp[0] & cin);
        bc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
              | (gp[3] & gp[2] & gp[1] & gg[0])
              | (gp[3] & gp[2] & gp[1] & gp[0] & cin);

        for (int k = 0; k < 4; k++) begin
            c[4*k]   = bc[k];
            c[4*k+1] = g[4*k] | (p[4*k] & bc[k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
                     | (p[4*k+1] & p[4*k] & bc[k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
                     | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & bc[k]);
        end

        s    = p ^ c;
        cout = bc[4];
    end
endmodule

module add64_sequencer (
    input  logic               clk,
    input  logic               rst_n,
    add64_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [63:0] opa;
    logic [63:0] opb;
    logic        cr;
    logic [1:0]  idx;
    logic [63:0] result_q;
    logic        cout_q;
    logic        ovf_q;

    logic        ready_i;
    logic        busy_i;
    logic        done_i;
    logic        accept;
    logic        last_slice;

    logic [15:0] slice_a;
    logic [15:0] slice_b;
    logic [15:0] slice_s;
    logic        slice_co;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        ready_i    = 1'b0;
        busy_i     = 1'b0;
        done_i     = 1'b0;
        accept     = 1'b0;
        last_slice = (idx == 2'd3);
        case (state)
            IDLE: begin
                ready_i = 1'b1;
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy_i = 1'b1;
                if (last_slice) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                ready_i = 1'b1;
                done_i  = 1'b1;
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // {idx, 4'b0} is 16*idx: selects the active slice of each operand.
    assign slice_a = opa[{idx, 4'b0000} +: 16];
    assign slice_b = opb[{idx, 4'b0000} +: 16];

    add64_sequencer_cla16 u_slice (
        .x    (slice_a),
        .y    (slice_b),
        .cin  (cr),
        .s    (slice_s),
        .cout (slice_co)
    );

    // Subtract is a + ~b + 1: the +1 enters as the initial slice carry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            opa      <= '0;
            opb      <= '0;
            cr       <= 1'b0;
            idx      <= 2'd0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (accept) begin
            opa <= bus.a;
            opb <= bus.sub ? ~bus.b : bus.b;
            cr  <= bus.sub;
            idx <= 2'd0;
        end else if (state == RUN) begin
            result_q[{idx, 4'b0000} +: 16] <= slice_s;
            cr  <= slice_co;
            idx <= idx + 2'd1;
            if (last_slice) begin
                cout_q <= slice_co;
                // Overflow seen on the effective operands (b already inverted).
                ovf_q  <= (opa[63] == opb[63]) & (slice_s[15] != opa[63]);
            end
        end
    end

    assign bus.ready  = ready_i;
    assign bus.busy   = busy_i;
    assign bus.done   = done_i;
    assign bus.result = result_q;
    assign bus.cout   = cout_q;
    assign bus.ovf    = ovf_q;
endmodule

// File: tb/tb_add64_sequencer.sv
// ---------------------------------------------------------------------------
// tb_add64_sequencer
// Scoreboard bench: a reference process watches each rising edge, decides
// from the timing rules alone whether the sequencer takes a start, and
// pushes the arithmetic answer plus the edge at which done must appear.
// A monitor on the falling edge pops and compares when done is due, and
// checks ready/busy/done every cycle and result hold while idle.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_add64_sequencer;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    add64_sequencer_if bus ();

    add64_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [63:0] res;
        logic        co;
        logic        ov;
        int          done_edge;
    } exp_t;

    exp_t        q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          edge_n = 0;
    int          free_edge = 0;
    bit          mon_en = 1'b0;
    logic [63:0] held_res = '0;
    logic        held_co = 1'b0;
    logic        held_ov = 1'b0;

    exp_t        m_e;
    bit          m_busy;
    bit          m_done;

    function automatic exp_t ref_model(logic s, logic [63:0] x, logic [63:0] y, int de);
        exp_t        e;
        logic [64:0] w;
        if (!s) begin
            w     = {1'b0, x} + {1'b0, y};
            e.res = w[63:0];
            e.co  = w[64];
            e.ov  = (x[63] == y[63]) && (e.res[63] != x[63]);
        end else begin
            e.res = x - y;
            e.co  = (x >= y);
            e.ov  = (x[63] != y[63]) && (e.res[63] != x[63]);
        end
        e.done_edge = de;
        return e;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // Reference: acceptance decided purely from elapsed edges since the
    // previous acceptance (one op every 5 edges at most) and reset.
    always @(posedge clk) begin
        edge_n++;
        if (rst_n !== 1'b1) begin
            q.delete();
            held_res  = '0;
            held_co   = 1'b0;
            held_ov   = 1'b0;
            mon_en    = 1'b1;
            free_edge = edge_n + 1;
        end else if (bus.start === 1'b1 && edge_n >= free_edge) begin
            q.push_back(ref_model(bus.sub, bus.a, bus.b, edge_n + 4));
            free_edge = edge_n + 5;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            m_busy = (q.size() != 0) && (edge_n < q[0].done_edge);
            m_done = (q.size() != 0) && (edge_n == q[0].done_edge);
            chk("busy",  64'(bus.busy),  64'(m_busy));
            chk("ready", 64'(bus.ready), 64'(!m_busy));
            chk("done",  64'(bus.done),  64'(m_done));
            if (m_done) begin
                m_e = q.pop_front();
                chk("result", bus.result,     m_e.res);
                chk("cout",   64'(bus.cout),  64'(m_e.co));
                chk("ovf",    64'(bus.ovf),   64'(m_e.ov));
                held_res = m_e.res;
                held_co  = m_e.co;
                held_ov  = m_e.ov;
            end else if (!m_busy) begin
                chk("hold_result", bus.result,    held_res);
                chk("hold_cout",   64'(bus.cout), 64'(held_co));
                chk("hold_ovf",    64'(bus.ovf),  64'(held_ov));
            end
        end
    end

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    // One operation; operands scrambled every cycle after acceptance.
    task automatic issue(logic s, logic [63:0] x, logic [63:0] y);
        @(negedge clk);
        bus.start = 1'b1;
        bus.sub   = s;
        bus.a     = x;
        bus.b     = y;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) begin
            bus.a   = rnd64();
            bus.b   = rnd64();
            bus.sub = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        issue(1'b0, 64'h0000_0000_0000_FFFF, 64'h1);
        issue(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1);
        issue(1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1);
        issue(1'b1, 64'h0,                   64'h1);
        issue(1'b1, 64'h8000_0000_0000_0000, 64'h1);
        issue(1'b1, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0);

        // Start pulses and operand churn while running are ignored.
        @(negedge clk);
        bus.start = 1'b1;
        bus.sub   = 1'b0;
        bus.a     = rnd64();
        bus.b     = rnd64();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.start = 1'($urandom_range(0, 1));
            bus.sub   = 1'($urandom_range(0, 1));
            bus.a     = rnd64();
            bus.b     = rnd64();
        end
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);

        // Reset at the idx=2 slice edge, then 5+7 right after release.
        bus.start = 1'b1;
        bus.a     = rnd64();
        bus.b     = rnd64();
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        bus.start = 1'b1;
        bus.sub   = 1'b0;
        bus.a     = 64'd5;
        bus.b     = 64'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);

        // start held high: three back-to-back operations, operands change
        // every cycle so each result must reflect its own acceptance edge.
        bus.start = 1'b1;
        for (int i = 0; i < 15; i++) begin
            bus.sub = 1'($urandom_range(0, 1));
            bus.a   = rnd64();
            bus.b   = rnd64();
            @(negedge clk);
        end
        bus.start = 1'b0;
        repeat (6) @(negedge clk);

        // Random traffic with dense start requests.
        for (int i = 0; i < 60; i++) begin
            bus.start = ($urandom_range(0, 3) != 0);
            bus.sub   = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       bus.a = 64'hFFFF_FFFF_FFFF_FFFF;
                1:       bus.a = 64'h8000_0000_0000_0000;
                default: bus.a = rnd64();
            endcase
            bus.b = ($urandom_range(0, 3) == 0) ? 64'h1 : rnd64();
            @(negedge clk);
        end
        bus.start = 1'b0;
        repeat (8) @(negedge clk);

        chk("drain", 64'(q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/add64_sequencer.md
ADD64_SEQUENCER -- requirements
Module: add64_sequencer

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 64 bits and slice width at 16 bits.
REQ-002 The block SHALL have one clock; reset SHALL be synchronous and active-low.
REQ-003 clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 start  input  1  request to begin an operation; sampled only while ready=1.
REQ-006 sub  input  1  0 = A+B, 1 = A-B; sampled with start.
REQ-007 a  input  64  operand A; sampled with start.
REQ-008 b  input  64  operand B; sampled with start.
REQ-009 ready  output  1  block can accept start this cycle.
REQ-010 busy  output  1  operation in progress.
REQ-011 done  output  1  one-cycle pulse; result, cout and ovf are valid.
REQ-012 result  output  64  sum or difference.
REQ-013 cout  output  1  carry out of bit 63; for subtract, 1 means no borrow.
REQ-014 ovf  output  1  two's-complement signed overflow.

Function
REQ-015 The block SHALL contain exactly one 16-bit carry-lookahead adder slice (A16, B16, cin -> S16, cout), and SHALL perform at most one slice add per cycle.
REQ-016 The FSM SHALL have states IDLE, RUN and DONE.
REQ-017 Outputs SHALL decode from state: ready = IDLE or DONE; busy = RUN; done = DONE.
REQ-018 Acceptance SHALL occur at a rising edge where ready=1 and start=1.
REQ-019 On acceptance, the block SHALL latch a into opa, latch (sub ? ~b : b) into opb, set carry register cr to sub, clear slice index idx, and go to RUN.
REQ-020 In RUN, the slice SHALL compute opa[16*idx+:16] + opb[16*idx+:16] + cr.
REQ-021 At each RUN edge, the block SHALL write the slice sum into result[16*idx+:16], load cr with the slice carry-out, and increment idx.
REQ-022 At the RUN edge where idx=3, the block SHALL also load cout with the slice carry-out and ovf with (opa[63]==opb[63]) & (sum[63]!=opa[63]), then go to DONE.
REQ-023 DONE SHALL last one cycle, then go to RUN if a new operation is accepted, otherwise to IDLE.
REQ-024 Latency SHALL be fixed: acceptance at edge k, slice edges k+1 to k+4, done=1 between edges k+4 and k+5.
REQ-025 Sustained throughput SHALL be one operation per 5 cycles when start is held high.
REQ-026 A start while busy=1 SHALL be ignored, with no queueing and no effect on the running operation.
REQ-027 Changes to a, b or sub after acceptance SHALL NOT affect the running operation.
REQ-028 During RUN, result SHALL be partially updated and is undefined for consumers; after DONE, result, cout and ovf SHALL hold until the next acceptance.
REQ-029 idx SHALL wrap naturally after 3 (2-bit counter); the slice counter SHALL have no other exit path.

Reset
REQ-030 With rst_n=0 at an edge, state SHALL go to IDLE, idx and cr SHALL be 0, opa and opb SHALL be 0, and result, cout, ovf, done and busy SHALL be 0 with ready=1.
REQ-031 Reset during RUN or DONE SHALL abort the operation, with no done pulse for it.
REQ-032 An operation SHALL be accepted at the first edge after rst_n returns high if start=1.

Verification
REQ-033 Add 0x0000_0000_0000_FFFF + 0x1 -> result 0x0000_0000_0001_0000, cout=0, ovf=0, done one cycle at k+4..k+5.
REQ-034 Add 0xFFFF_FFFF_FFFF_FFFF + 0x1 -> result 0, cout=1, ovf=0; the carry propagates across all four slices.
REQ-035 Add 0x7FFF_FFFF_FFFF_FFFF + 0x1 -> 0x8000_0000_0000_0000, ovf=1; sub 0x0 - 0x1 -> 0xFFFF_FFFF_FFFF_FFFF, cout=0, ovf=0; sub 0x8000_0000_0000_0000 - 0x1 -> ovf=1.
REQ-036 Start pulses during RUN plus a/b toggled every cycle after acceptance -> only the first operation's result is produced, with a single done.
REQ-037 rst_n=0 at idx=2 -> all outputs 0 next cycle, no done; a following start of 5+7 gives result 12 after the normal latency.
REQ-038 start held high for 3 operations -> done pulses 5 cycles apart, and each result matches its operands sampled at its acceptance edge.
